// File: rtl/fxp_div_pkg.sv
// Shared constants and types for the Q6.4 restoring divider.
// W, F and QW describe the operand and quotient layout, and Q_SAT is the saturation value.
package fxp_div_pkg;

   localparam int W  = 10;
   localparam int F  = 4;
   localparam int QW = W + F;
   localparam int CW = $clog2(QW);

   localparam logic [W-1:0] Q_SAT = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fxp_divider_if.sv
// Start/busy/valid handshake bundle between a host and the fixed-point divider.
// The host drives the request side and observes the result side.
interface fxp_divider_if;
   import fxp_div_pkg::*;

   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         dvz;
   logic         ovf;
   logic         busy;
   logic         valid;
   logic [W-1:0] q_out;

   modport master (
      output start, a_in, b_in,
      input  dvz, ovf, busy, valid, q_out
   );

   modport slave (
      input  start, a_in, b_in,
      output dvz, ovf, busy, valid, q_out
   );

endinterface

// File: rtl/fxp_div_datapath.sv
// Restoring shift-subtract core: one quotient bit per step.
// The dividend and quotient share one shift register, because quotient bits fill the vacated LSBs.
module fxp_div_datapath
   import fxp_div_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sclr,
   input  logic          load,
   input  logic          step,
   input  logic [W-1:0]  a_in,
   input  logic [W-1:0]  b_in,
   output logic [QW-1:0] quo_nxt,
   output logic          last
);

   logic [QW-1:0] dq;
   logic [W:0]    rem;
   logic [W-1:0]  b;
   logic [CW-1:0] cnt;

   logic [W+1:0]  rem_sh;
   logic [W+1:0]  diff;
   logic          ge;
   logic [W:0]    rem_nxt;

   // The remainder always stays below b, so a borrow in the top bit of diff means rem_sh < b.
   always_comb begin
      rem_sh  = {rem, dq[QW-1]};
      diff    = rem_sh - {2'b00, b};
      ge      = ~diff[W+1];
      rem_nxt = ge ? diff[W:0] : rem_sh[W:0];
      quo_nxt = {dq[QW-2:0], ge};
   end

   assign last = (cnt == CW'(QW - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dq  <= '0;
         rem <= '0;
         b   <= '0;
         cnt <= '0;
      end else if (sclr) begin
         dq  <= '0;
         rem <= '0;
         b   <= '0;
         cnt <= '0;
      end else if (load) begin
         dq  <= {a_in, {F{1'b0}}};
         rem <= '0;
         b   <= b_in;
         cnt <= '0;
      end else if (step) begin
         dq  <= quo_nxt;
         rem <= rem_nxt;
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/fxp_divider.sv
// Top of the Q6.4 sequential divider: control FSM plus result and flag registers.
// Division by zero completes on the accept edge; every other division takes QW steps.
module fxp_divider
   import fxp_div_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sclr,
   fxp_divider_if.slave  dif
);

   state_t        state;
   logic          busy;
   logic          valid;
   logic          dvz;
   logic          ovf;
   logic [W-1:0]  q_out;

   logic          load;
   logic          step;
   logic          last;
   logic [QW-1:0] quo_nxt;

   function automatic logic [W-1:0] sat_q(input logic [QW-1:0] q);
      return (|q[QW-1:W]) ? Q_SAT : q[W-1:0];
   endfunction

   assign load = (state != RUN) && dif.start && !sclr;
   assign step = (state == RUN);

   fxp_div_datapath u_dp (
      .clk     (clk),
      .rst_n   (rst_n),
      .sclr    (sclr),
      .load    (load),
      .step    (step),
      .a_in    (dif.a_in),
      .b_in    (dif.b_in),
      .quo_nxt (quo_nxt),
      .last    (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         valid <= 1'b0;
         dvz   <= 1'b0;
         ovf   <= 1'b0;
         q_out <= '0;
      end else if (sclr) begin
         state <= IDLE;
         busy  <= 1'b0;
         valid <= 1'b0;
         dvz   <= 1'b0;
         ovf   <= 1'b0;
         q_out <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (dif.start) begin
                  valid <= 1'b0;
                  dvz   <= 1'b0;
                  ovf   <= 1'b0;
                  q_out <= '0;
                  if (dif.b_in == '0) begin
                     state <= DONE;
                     dvz   <= 1'b1;
                     valid <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               // The final quotient bit is folded in from quo_nxt, so the result lands on the last step edge.
               if (last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  valid <= 1'b1;
                  ovf   <= |quo_nxt[QW-1:W];
                  q_out <= sat_q(quo_nxt);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dif.busy  = busy;
   assign dif.valid = valid;
   assign dif.dvz   = dvz;
   assign dif.ovf   = ovf;
   assign dif.q_out = q_out;

endmodule

// File: tb/tb_fxp_divider.sv
// Scoreboard bench for fxp_divider: the stimulus pushes model results into a queue.
// A negedge monitor pops and compares each completed result against that queue.
module tb_fxp_divider;
   import fxp_div_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic sclr  = 1'b0;

   fxp_divider_if dif ();

   fxp_divider dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sclr  (sclr),
      .dif   (dif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] q;
      logic         dvz;
      logic         ovf;
      int           lat;
      int           bsy;
      int           acc;
   } exp_t;

   exp_t exp_q[$];
   int   vectors    = 0;
   int   miscompares = 0;
   int   cyc        = 0;
   int   last_acc   = -1;
   int   brun       = 0;
   logic vprev      = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: quotient = floor(a*2^F / b) on plain integers, then flagged or saturated.
   function automatic exp_t model(input int a, input int b);
      exp_t e;
      int   full;
      e.acc = 0;
      if (b == 0) begin
         e.q = '0; e.dvz = 1'b1; e.ovf = 1'b0; e.lat = 0; e.bsy = 0;
      end else begin
         full  = (a * 16) / b;
         e.dvz = 1'b0;
         e.ovf = (full > 1023);
         e.q   = (full > 1023) ? 10'h3FF : W'(full);
         e.lat = 14;
         e.bsy = 14;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      chk("busy_valid_excl", {31'd0, dif.busy & dif.valid}, 32'd0);
      chk("dvz_ovf_excl", {31'd0, dif.dvz & dif.ovf}, 32'd0);
      if (!dif.busy && !dif.valid) brun = 0;
      else if (dif.busy) brun++;
      if (dif.valid && (!vprev || cyc == last_acc)) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("q_out", {22'd0, dif.q_out}, {22'd0, e.q});
            chk("dvz", {31'd0, dif.dvz}, {31'd0, e.dvz});
            chk("ovf", {31'd0, dif.ovf}, {31'd0, e.ovf});
            chk("latency", cyc - e.acc, e.lat);
            chk("busy_cycles", brun, e.bsy);
            brun = 0;
         end
      end
      vprev = dif.valid;
   end

   task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit accept);
      exp_t e;
      @(negedge clk);
      dif.start = 1'b1;
      dif.a_in  = a;
      dif.b_in  = b;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      dif.a_in  = W'($urandom);
      dif.b_in  = W'($urandom);
      if (accept) begin
         e        = model(int'(a), int'(b));
         e.acc    = cyc;
         last_acc = cyc;
         exp_q.push_back(e);
         chk("accept_busy", {31'd0, dif.busy}, {31'd0, b != 0});
         chk("accept_valid", {31'd0, dif.valid}, {31'd0, b == 0});
      end
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (!dif.busy) done = 1;
      end
      if (!done) chk("timeout_busy", 32'd1, 32'd0);
      @(negedge clk);
   endtask

   task automatic chk_cleared(input string name);
      chk({name, "_busy"},  {31'd0, dif.busy},  32'd0);
      chk({name, "_valid"}, {31'd0, dif.valid}, 32'd0);
      chk({name, "_q"},     {22'd0, dif.q_out}, 32'd0);
      chk({name, "_dvz"},   {31'd0, dif.dvz},   32'd0);
      chk({name, "_ovf"},   {31'd0, dif.ovf},   32'd0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      int           sel;
      dif.start = 1'b0;
      dif.a_in  = '0;
      dif.b_in  = '0;
      #1 rst_n = 1'b0;
      #12;
      chk_cleared("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases from the test plan
      do_start(10'b0001110100, 10'b0000001000, 1); wait_idle();
      do_start(10'd100, 10'd0, 1);                 wait_idle();
      do_start(10'h3FF, 10'd1, 1);                 wait_idle();
      do_start(10'd16, 10'd48, 1);                 wait_idle();

      // Start while busy is ignored, and operand changes after accept are harmless
      do_start(10'd160, 10'd32, 1);
      repeat (2) @(posedge clk);
      do_start(10'd999, 10'd0, 0);
      wait_idle();
      do_start(10'd16, 10'd48, 1);                 wait_idle();
      do_start(10'd5, 10'd0, 1);                   wait_idle();
      do_start(10'd7, 10'd0, 1);                   wait_idle();

      // Synchronous clear part way through RUN
      do_start(10'd300, 10'd7, 1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      sclr = 1'b1;
      @(posedge clk);
      #1;
      sclr = 1'b0;
      exp_q.delete();
      chk_cleared("sclr_abort");
      repeat (20) @(negedge clk);

      // Asynchronous reset between edges during RUN
      do_start(10'd500, 10'd9, 1);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk_cleared("rst_abort");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // Asynchronous reset while a nonzero result is held
      do_start(10'd300, 10'd16, 1); wait_idle();
      #2 rst_n = 1'b0;
      #1;
      chk_cleared("rst_done");
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized divisions, some with a start pulse while busy
      for (int n = 0; n < 60; n++) begin
         ra  = W'($urandom_range(0, 1023));
         sel = $urandom_range(0, 9);
         if (sel == 0)      rb = '0;
         else if (sel < 4)  rb = W'($urandom_range(1, 15));
         else               rb = W'($urandom_range(1, 1023));
         do_start(ra, rb, 1);
         if (rb != 0 && $urandom_range(0, 3) == 0) do_start(W'($urandom), W'($urandom), 0);
         wait_idle();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("pending_results", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fxp_divider.md
Name: fxp_divider

Overview:
- Sequential unsigned fixed-point divider: q = a / b, with a, b and q all 10-bit unsigned Q6.4 (6 integer bits, 4 fraction bits).
- Uses a restoring shift-subtract algorithm that produces one quotient bit per clock.
- Flags divide-by-zero and quotient overflow.
- Sits behind a simple start/busy/valid handshake for use by a host controller or datapath.

Parameters:
- W, 10, operand and quotient width in bits.
- F, 4, number of fraction bits in every operand and in the quotient.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- sclr  input  1  synchronous active-high clear. Same effect as reset, applied on a clock edge. Has priority over start.
- start  input  1  request a division. Sampled only while idle.
- a_in  input  W  dividend, Q6.4.
- b_in  input  W  divisor, Q6.4.
- dvz  output  1  divide-by-zero flag for the last result.
- ovf  output  1  overflow flag for the last result.
- busy  output  1  high while a division is in progress.
- valid  output  1  high when q_out, dvz and ovf hold a completed result.
- q_out  output  W  quotient, Q6.4, truncated toward zero.

Behaviour:
- Reset and clear values: when rst_n is low (asynchronous), or sclr is high at a rising edge, all of the following go to 0: outputs, state, counter, registers. State returns to IDLE.
- Either reset source aborts a division in progress. No result is produced for the aborted division.
- States:
  - IDLE: waiting for start.
  - RUN: iterating.
  - DONE: result held.
- Accept: at a rising edge in IDLE or DONE with start=1 and sclr=0:
  - a_in and b_in are captured on that same edge.
  - valid, dvz, ovf and q_out are cleared.
- Divide by zero:
  - If the captured b_in is 0: go straight to DONE on that edge.
  - Outputs after the edge: dvz=1, ovf=0, q_out=0, valid=1, busy=0.
  - Latency is 1 cycle.
- Normal division:
  - Go to RUN and set busy=1.
  - Internal dividend is {a, F zeros}, 14 bits. The remainder register is W+1 bits.
  - Each RUN edge: shift the next dividend bit into the remainder. If remainder >= b, subtract b and shift a 1 into the quotient; otherwise shift in 0.
  - After W+F = 14 RUN edges, go to DONE with busy=0 and valid=1.
  - valid is observed 14 cycles after the accept edge.
- Overflow:
  - The full quotient is 14 bits. If any of its upper F bits is 1, then ovf=1 and q_out saturates to 10'h3FF.
  - Otherwise q_out = low W bits of the quotient and ovf=0.
- DONE: q_out, dvz, ovf and valid hold until the next accepted start, sclr, or rst_n.
- start asserted in RUN is ignored. It is not queued.
- Changes on a_in/b_in after the accept edge do not affect the result.
- busy and valid are never high together.
- At most one of dvz and ovf is high.

Decomposition:
- Shared package fxp_div_pkg holds:
  - constants W=10, F=4, QW=W+F=14;
  - state enum {IDLE, RUN, DONE};
  - constant Q_SAT = all ones.
- Natural split into two modules:
  - fxp_div_datapath: operand, remainder and quotient registers, subtractor, counter.
  - Top fxp_divider: contains the FSM and the flag/output logic.

Test Plan:
- Normal division: reset, then start with a=10'b0001110100 (7.25) and b=10'b0000001000 (0.5).
  - Required: busy=1 for 14 cycles.
  - Then valid=1, q_out=10'd232 (14.5), dvz=0, ovf=0.
- Divide by zero: a=10'd100, b=0.
  - Required: one edge later valid=1, dvz=1, ovf=0, q_out=0, busy never high.
- Overflow: a=10'h3FF (63.9375), b=10'd1 (0.0625).
  - Required: after 14 cycles valid=1, ovf=1, q_out=10'h3FF.
- Truncating fraction: a=10'd16 (1.0), b=10'd48 (3.0).
  - Required: q_out=10'd5 (0.3125), no flags.
- Handshake robustness: start a=10'd160, b=10'd32.
  - While busy: pulse start with b=0 and change a_in. The result must still be q_out=10'd80 (10/2 = 5.0), dvz=0.
  - A new start in DONE clears valid on the accept edge.
- Abort:
  - Assert sclr 5 cycles into RUN: the next edge gives busy=0, valid=0, q_out=0.
  - Repeat with rst_n pulled low between edges: outputs clear immediately, without waiting for a clock edge.
